// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

    localparam logic [31:0] NOP                = 32'h00000013;
    localparam logic [3:0]  EXC_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0]  EXC_IACCESS_FAULT  = 4'd1;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

    // Output-stage contents after reset: empty entry carrying a NOP.
    localparam fetch_entry_t ENTRY_RESET = '{
        pc:       64'h0,
        instr:    NOP,
        exc_en:   1'b0,
        exc_code: 4'h0,
        exc_val:  64'h0
    };

endpackage

// File: rtl/ifetch_skid_buf.sv
// rtl/ifetch_skid_buf.sv - 2-entry FIFO of fetch entries with flush
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all buffered entries (takes priority over push/pop)
//   push, push_entry  write one entry (caller guarantees count < 2)
//   pop               remove head entry (caller guarantees count > 0)
//   head              oldest entry; stable while not popped
//   count             number of buffered entries, 0..2 (registered)
module ifetch_skid_buf
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t ent0;
    fetch_entry_t ent1;
    logic [1:0]   cnt;
    logic [1:0]   wr_slot;

    // A pop shifts ent1 into ent0 this cycle, so a simultaneous push lands
    // one slot lower than the current count.
    assign wr_slot = cnt - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0 <= ENTRY_RESET;
            ent1 <= ENTRY_RESET;
            cnt  <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            if (pop) begin
                ent0 <= ent1;
            end
            if (push) begin
                if (wr_slot == 2'd0) begin
                    ent0 <= push_entry;
                end else begin
                    ent1 <= push_entry;
                end
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = ent0;
    assign count = cnt;

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with fault tagging and redirect
//
// Optional feature macro: IFETCH_SKID_BUF_EN (2-entry output FIFO instead of
// a single output register; removes the out_ready -> capture path).
//
// Ports:
//   clk, rst                                    clock, synchronous active-high reset
//   imem_addr                                   fetch address (the PC register)
//   imem_instr                                  instruction word for imem_addr
//   imem_exc_en/imem_exc_code/imem_exc_val      memory fetch fault
//   redirect_en/redirect_pc                     branch/trap redirect
//   out_valid/out_ready                         handshake to decode
//   out_pc/out_instr                            head entry
//   out_exc_en/out_exc_code/out_exc_val         exception tagged to head entry
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    state_t       state;
    logic [63:0]  pc;
    fetch_entry_t cap_entry;
    logic         cap_allowed;
    logic         capture;
    fetch_entry_t head;
    logic         head_valid;

    assign imem_addr = pc;

    // Misalignment is detected locally and outranks any memory-side fault.
    always_comb begin
        cap_entry = '{pc: pc, instr: imem_instr, exc_en: 1'b0,
                      exc_code: 4'h0, exc_val: 64'h0};
        if (pc[1:0] != 2'b00) begin
            cap_entry.instr    = NOP;
            cap_entry.exc_en   = 1'b1;
            cap_entry.exc_code = EXC_IADDR_MISALIGN;
            cap_entry.exc_val  = pc;
        end else if (imem_exc_en) begin
            cap_entry.instr    = NOP;
            cap_entry.exc_en   = 1'b1;
            cap_entry.exc_code = imem_exc_code;
            cap_entry.exc_val  = imem_exc_val;
        end
    end

    assign capture = (state == FETCH) && !redirect_en && cap_allowed;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= FETCH;
        end else if (redirect_en) begin
            pc    <= redirect_pc;
            state <= FETCH;
        end else if (capture) begin
            // A faulting entry parks the PC on the faulting address.
            if (cap_entry.exc_en) begin
                state <= HALT;
            end else begin
                pc <= pc + 64'd4;
            end
        end
    end

`ifdef IFETCH_SKID_BUF_EN
    logic [1:0] fifo_count;

    ifetch_skid_buf u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_en),
        .push       (capture),
        .push_entry (cap_entry),
        .pop        (out_valid && out_ready),
        .head       (head),
        .count      (fifo_count)
    );

    assign cap_allowed = (fifo_count != 2'd2);
    assign head_valid  = (fifo_count != 2'd0);
`else
    fetch_entry_t out_q;
    logic         out_valid_q;

    assign cap_allowed = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= ENTRY_RESET;
            out_valid_q <= 1'b0;
        end else if (redirect_en) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_q       <= cap_entry;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign head       = out_q;
    assign head_valid = out_valid_q;
`endif

    assign out_valid    = head_valid;
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign out_exc_en   = head.exc_en;
    assign out_exc_code = head.exc_code;
    assign out_exc_val  = head.exc_val;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch against a program-order fetch model
module tb_ifetch;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP_W    = 32'h00000013;
    localparam logic [63:0] FAULT_LO = 64'h4000;
    localparam logic [63:0] FAULT_HI = 64'h4100;
`ifdef IFETCH_SKID_BUF_EN
    localparam logic [63:0] MAX_AHEAD = 64'd8;
`else
    localparam logic [63:0] MAX_AHEAD = 64'd4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .imem_exc_en  (imem_exc_en),
        .imem_exc_code(imem_exc_code),
        .imem_exc_val (imem_exc_val),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_exc_en   (out_exc_en),
        .out_exc_code (out_exc_code),
        .out_exc_val  (out_exc_val)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Instruction memory: two fixed words at 0/4, hashed words elsewhere,
    // access fault over [FAULT_LO, FAULT_HI).
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h00100093;
        if (a == 64'h4) return 32'h00200113;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0001;
    endfunction

    function automatic logic is_fault(input logic [63:0] a);
        return (a >= FAULT_LO) && (a < FAULT_HI);
    endfunction

    always_comb begin
        imem_instr    = mem_word(imem_addr);
        imem_exc_en   = is_fault(imem_addr);
        imem_exc_code = is_fault(imem_addr) ? 4'd1 : 4'hF;
        imem_exc_val  = is_fault(imem_addr) ? imem_addr : ~imem_addr;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];

    // Architectural view: decode sees a program-order walk from the last
    // redirect/reset target, ending at (and including) the first faulting PC.
    function automatic exp_t model_entry(input logic [63:0] p);
        exp_t e;
        e.pc = p;
        if (p[1:0] != 2'b00) begin
            e.instr = NOP_W; e.exc_en = 1'b1; e.code = 4'd0; e.val = p;
        end else if (is_fault(p)) begin
            e.instr = NOP_W; e.exc_en = 1'b1; e.code = 4'd1; e.val = p;
        end else begin
            e.instr = mem_word(p); e.exc_en = 1'b0; e.code = 4'd0; e.val = 64'h0;
        end
        return e;
    endfunction

    task automatic load_walk(input logic [63:0] start);
        logic [63:0] p;
        exp_t e;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 300; i++) begin
            e = model_entry(p);
            exp_q.push_back(e);
            if (e.exc_en) break;
            p = p + 64'd4;
        end
    endtask

    // Monitor: pops expected entries on every handshake, checks hold-while-stalled
    // and how far fetch runs ahead of decode.
    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic        prev_redir = 1'b0;
    logic        prev_rst   = 1'b1;
    logic [63:0] snap_pc, snap_val, diff;
    logic [31:0] snap_instr;
    logic        snap_exc;
    logic [3:0]  snap_code;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && !prev_redir && !prev_rst) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_pc", out_pc, snap_pc);
                chk("stall_instr", out_instr, snap_instr);
                chk("stall_exc", {out_exc_en, out_exc_code}, {snap_exc, snap_code});
                chk("stall_val", out_exc_val, snap_val);
            end
            if (exp_q.size() != 0) begin
                diff = imem_addr - exp_q[0].pc;
                chk("fetch_ahead_ok", (diff <= MAX_AHEAD) && (diff[1:0] == 2'b00), 1'b1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry_pc", out_pc, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("entry_pc", out_pc, mon_e.pc);
                    chk("entry_instr", out_instr, mon_e.instr);
                    chk("entry_exc_en", out_exc_en, mon_e.exc_en);
                    chk("entry_exc_code", out_exc_code, mon_e.code);
                    chk("entry_exc_val", out_exc_val, mon_e.val);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_redir = redirect_en;
            snap_pc    = out_pc;
            snap_instr = out_instr;
            snap_exc   = out_exc_en;
            snap_code  = out_exc_code;
            snap_val   = out_exc_val;
        end else begin
            prev_stall = 1'b0;
        end
        prev_rst = rst;
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic cyc(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            out_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : mode[0];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect_to(input logic [63:0] target, input logic rdy);
        out_ready   = rdy;
        redirect_en = 1'b1;
        redirect_pc = target;
        @(posedge clk);
        load_walk(target);
        #1;
        redirect_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_pc"}, out_pc, 64'h0);
        chk({tag, "_instr"}, out_instr, NOP_W);
        chk({tag, "_exc"}, {out_exc_en, out_exc_code}, 5'h0);
        chk({tag, "_val"}, out_exc_val, 64'h0);
        chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
    endtask

    logic [63:0] tgt;
    int          waited;

    initial begin
        rst         = 1'b1;
        out_ready   = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        repeat (2) @(posedge clk);
        load_walk(RESET_PC);
        #1;
        rst = 1'b0;

        // Reset values, then first entries one cycle apart.
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        chk("first_valid", out_valid, 1'b1);
        chk("first_pc", out_pc, 64'h0);
        chk("first_instr", out_instr, 32'h00100093);
        @(negedge clk);
        chk("second_valid", out_valid, 1'b1);
        chk("second_pc", out_pc, 64'h4);
        chk("second_instr", out_instr, 32'h00200113);
        @(posedge clk);
        #1;

        // Mid-stream stall then release.
        cyc(3, 0);
        cyc(4, 1);

        // Fill the output stage, then redirect.
        cyc(3, 0);
        redirect_to(64'h100, 1'b0);
        @(negedge clk);
        chk("redirect_flush_valid", out_valid, 1'b0);
        chk("redirect_imem_addr", imem_addr, 64'h100);
        @(posedge clk);
        #1;
        cyc(6, 1);

        // Access fault at 0x4000.
        redirect_to(64'h3FF0, 1'b1);
        cyc(12, 1);
        chk("fault_halt_addr", imem_addr, 64'h4000);
        chk("fault_halt_valid", out_valid, 1'b0);
        cyc(4, 2);
        chk("fault_still_halted", imem_addr, 64'h4000);

        // Misaligned redirect target.
        redirect_to(64'h102, 1'b1);
        cyc(6, 1);
        chk("misalign_halt_addr", imem_addr, 64'h102);
        chk("misalign_halt_valid", out_valid, 1'b0);

        // Randomized redirects and back-pressure.
        for (int ep = 0; ep < 40; ep++) begin
            case ($urandom_range(0, 5))
                0: tgt = {48'h0, 4'h0, 10'($urandom_range(0, 1023)), 2'b00};
                1: tgt = FAULT_LO - 64'(4 * $urandom_range(0, 12));
                2: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
                3: tgt = {48'h0, 4'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
                4: tgt = {$urandom, $urandom} & ~64'h3;
                default: tgt = 64'h4002;
            endcase
            redirect_to(tgt, 1'($urandom_range(0, 1)));
            cyc($urandom_range(3, 40), 2);
        end

        // Reset while an entry is held stalled, with a redirect also requested.
        redirect_to(64'h200, 1'b0);
        waited = 0;
        while (!out_valid && waited < 10) begin
            cyc(1, 0);
            waited++;
        end
        chk("stalled_before_reset", out_valid, 1'b1);
        rst         = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h500;
        @(posedge clk);
        load_walk(RESET_PC);
        #1;
        rst         = 1'b0;
        redirect_en = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        cyc(6, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the PC loaded at reset.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port imem_addr  output  64  fetch address to instruction memory pc_addr; SHALL equal the PC register (combinational from register only).
REQ-005 Port imem_instr  input  32  instruction returned combinationally for imem_addr.
REQ-006 Port imem_exc_en / imem_exc_code / imem_exc_val  input  1/4/64  fetch fault from memory (code 1 = access fault, val = bad PC).
REQ-007 Port redirect_en / redirect_pc  input  1/64  branch/trap redirect from execute/CSR.
REQ-008 Port out_valid  output  1  fetched entry available to decode.
REQ-009 Port out_ready  input  1  decode accepts entry; transfer when out_valid && out_ready.
REQ-010 Port out_pc / out_instr  output  64/32  PC and instruction of head entry.
REQ-011 Port out_exc_en / out_exc_code / out_exc_val  output  1/4/64  exception tagged to head entry.

Function
REQ-012 States SHALL be FETCH (issuing) and HALT (fault delivered; no issue until redirect).
REQ-013 In FETCH, when capture allowed, the block SHALL capture {pc, imem_instr, exc fields} into the output stage and set pc <= pc + 4 (64-bit, wraps modulo 2^64).
REQ-014 Fetch-to-out_valid latency SHALL be 1 cycle; back-to-back throughput 1 entry/cycle with out_ready held high.
REQ-015 If pc[1:0] != 0, the captured entry SHALL have out_instr = 32'h00000013, exc_en = 1, exc_code = 0 (address misaligned), exc_val = pc; imem_exc inputs ignored for that entry.
REQ-016 Otherwise, if imem_exc_en = 1, the captured entry SHALL carry instr 32'h00000013 and imem exc_code/exc_val unchanged.
REQ-017 Capturing any entry with exc_en = 1 SHALL move FETCH -> HALT with pc not incremented.
REQ-018 In HALT, nothing SHALL be captured; already-buffered entries SHALL still drain to decode.
REQ-019 redirect_en = 1 SHALL have highest priority: next cycle pc = redirect_pc, state = FETCH, all buffered entries flushed (out_valid = 0), no capture that cycle.
REQ-020 Redirect coinciding with an out_valid && out_ready transfer SHALL still complete that transfer, then flush.
REQ-021 Output fields SHALL be stable while out_valid && !out_ready.

Reset
REQ-022 On rst: pc = RESET_PC, state = FETCH, out_valid = 0, out_pc = 0, out_instr = 32'h00000013, out_exc_en = 0, out_exc_code = 0, out_exc_val = 0.
REQ-023 rst SHALL override redirect_en and any in-flight transfer; first capture occurs on the first cycle after rst deasserts.

Configuration
REQ-024 Macro IFETCH_SKID_BUF_EN defined: output stage SHALL be a 2-entry FIFO; capture allowed when registered count < 2; no combinational path from out_ready to capture or imem_addr.
REQ-025 Macro undefined: output stage SHALL be a single register; capture allowed when !out_valid || out_ready (combinational on out_ready).
REQ-026 Both builds SHALL produce identical accepted entry sequences for identical stimulus.

Structure
REQ-027 Package ifetch_pkg SHALL hold: NOP constant 32'h00000013, EXC_IADDR_MISALIGN = 4'd0, EXC_IACCESS_FAULT = 4'd1, state enum {FETCH, HALT}, fetch-entry struct {pc, instr, exc_en, exc_code, exc_val}.
REQ-028 Sub-module ifetch_skid_buf (2-entry FIFO of fetch entries, with flush input) SHALL be instantiated only when IFETCH_SKID_BUF_EN is defined.

Verification
REQ-029 Reset, RESET_PC=0x0, out_ready=1, mem words 0x00100093,0x00200113 -> out_valid cycle 1; entries (pc 0x0, 0x00100093), (pc 0x4, 0x00200113) on consecutive cycles.
REQ-030 out_ready=0 for 3 cycles mid-stream -> outputs stable; no entry lost or duplicated after release; skid build imem_addr advances at most 2 entries past last accepted.
REQ-031 redirect_en=1, redirect_pc=0x100 while 2 entries buffered -> next cycle out_valid=0; following entry pc=0x100.
REQ-032 pc reaches 0x4000 (imem returns exc_en=1, code 1) -> entry exc_en=1, code=1, val=0x4000, instr NOP; state HALT; imem_addr held at 0x4000; no further entries until redirect.
REQ-033 redirect_pc=0x102 -> entry exc_en=1, code=0, val=0x102; HALT.
REQ-034 rst asserted with out_valid=1 and out_ready=0 -> next cycle all outputs at reset values, pc=RESET_PC.
